rca_adder: RTL and testbench

- Parameterised ripple-carry adder built from a chain of 1-bit full-adder cells.
- Sum and per-stage carries are produced combinationally, with zero latency.
- A registered copy of the result is also provided for pipelined consumers.
- Used as the basic adder datapath element. Default width is 4 bits.

---
 rtl/rca_adder.sv | 76 +++++++
 tb/tb_rca_adder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rca_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rca_adder                                              |
// | Description : Parameterised ripple-carry adder from 1-bit full-adder |
// |               cells, with combinational and registered results.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] cout_q
);

    // w_carry[i] is the carry into stage i; w_carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_y_q;
    logic [WIDTH-1:0] r_cout_q;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            rca_fa_cell u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (w_carry[i]),
                .s  (w_sum[i]),
                .co (w_carry[i+1])
            );
        end
    endgenerate

    assign y    = w_sum;
    assign cout = w_carry[WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q    <= '0;
            r_cout_q <= '0;
        end else begin
            r_y_q    <= w_sum;
            r_cout_q <= w_carry[WIDTH:1];
        end
    end

    assign y_q    = r_y_q;
    assign cout_q = r_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rca_adder                                           |
// | Description : Scoreboard bench for rca_adder against an arithmetic   |
// |               reference model.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

module tb_rca_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] cout;
    logic [W-1:0] y;
    logic [W-1:0] y_q;
    logic [W-1:0] cout_q;

    int n_tests;
    int n_fail;

    // Each entry is {expected cout, expected y} for the next capture edge.
    logic [2*W-1:0] sb_q[$];

    rca_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .cout   (cout),
        .y      (y),
        .y_q    (y_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry out of stage i is bit i+1 of the sum of the low i+1 bits of each operand.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input logic mc);
        logic [W-1:0] my;
        logic [W-1:0] mco;
        int           full;
        int           part;
        int           mask;
        full = int'(ma) + int'(mb) + int'(mc);
        my   = W'(full % (1 << W));
        for (int i = 0; i < W; i++) begin
            mask   = (1 << (i + 1)) - 1;
            part   = (int'(ma) & mask) + (int'(mb) & mask) + int'(mc);
            mco[i] = ((part >> (i + 1)) & 1) != 0;
        end
        return {mco, my};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (a=%h b=%h cin=%b)", name, got, exp, a, b, cin);
        end
    endtask

    task automatic check_comb(output logic [2*W-1:0] e);
        e = model(a, b, cin);
        check("y", y, e[W-1:0]);
        check("cout", cout, e[2*W-1:W]);
    endtask

    // Drives just after a rising edge, checks combinational outputs at the
    // falling edge and queues the value the next rising edge must capture.
    task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        logic [2*W-1:0] e;
        @(posedge clk);
        #1;
        a   = ta;
        b   = tb;
        cin = tc;
        @(negedge clk);
        check_comb(e);
        sb_q.push_back(e);
    endtask

    task automatic mid_reset();
        logic [2*W-1:0] e;
        #1 rst_n = 1'b0;
        #1;
        check("y_q_midrst", y_q, '0);
        check("cout_q_midrst", cout_q, '0);
        check_comb(e);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: registered outputs are valid a few ns after every rising edge.
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("y_q", y_q, e[W-1:0]);
                check("cout_q", cout_q, e[2*W-1:W]);
            end
        end
    end

    initial begin
        logic [2*W-1:0] e;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        a       = 4'h7;
        b       = 4'h5;
        cin     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_comb(e);
        check("y_q_rst", y_q, '0);
        check("cout_q_rst", cout_q, '0);
        rst_n = 1'b1;
        sb_q.push_back(e);

        apply(4'h0, 4'h0, 1'b0);
        apply(4'h9, 4'h0, 1'b0);
        apply(4'hF, 4'h0, 1'b1);
        apply(4'hF, 4'hF, 1'b1);
        apply(4'h8, 4'h8, 1'b0);
        apply(4'hF, 4'hF, 1'b0);
        apply(4'h0, 4'h0, 1'b1);

        for (int i = 0; i < 128; i++) begin
            apply(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), 1'b0);
            if (i == 64) mid_reset();
        end

        for (int i = 0; i < 16; i++) begin
            apply(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #5;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
